// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin sharing of one combinational ALU between two requesters
module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [3:0]       req_op0,
  input  logic [3:0]       req_op1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_illegal,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_code;
  logic             any_req;
  logic             gnt;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b0111, 4'b1100, 4'b1101: op_legal = 1'b1;
      default:                   op_legal = 1'b0;
    endcase
  endfunction

  // A tie goes to the port that did not win last; otherwise the lone requester wins.
  assign any_req   = |req_valid;
  assign gnt       = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
  assign req_ready = (state == IDLE && any_req) ? (gnt ? 2'b10 : 2'b01) : 2'b00;

  assign resp_valid = (state == RESP) ? {owner, ~owner} : 2'b00;
  assign busy       = (state != IDLE);

  assign alu_a  = op_a;
  assign alu_b  = op_b;
  assign alu_op = op_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      op_code      <= 4'b0000;
      resp_result  <= '0;
      resp_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The winner is always a valid port, so any request here is a handshake.
          if (any_req) begin
            op_a       <= gnt ? req_a1  : req_a0;
            op_b       <= gnt ? req_b1  : req_b0;
            op_code    <= gnt ? req_op1 : req_op0;
            owner      <= gnt;
            last_grant <= gnt;
            state      <= EXEC;
          end
        end
        EXEC: begin
          resp_result  <= alu_result;
          resp_illegal <= ~op_legal(op_code);
          state        <= RESP;
        end
        RESP: begin
          if (resp_ready[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed vector bench for alu_share_arb with a behavioural ALU
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_op0, req_op1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_result;
  logic        resp_illegal;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        busy;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_illegal(resp_illegal),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .busy(busy)
  );

  // Reference ALU: SLT unsigned, illegal codes return 0.
  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
      4'b1100: alu_result = ~(alu_a | alu_b);
      4'b1101: alu_result = alu_a << alu_b[4:0];
      default: alu_result = 32'h0;
    endcase
  end

  typedef struct {
    logic        port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic        exp_illegal;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input logic port, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    if (port) begin
      req_a1 = a; req_b1 = b; req_op1 = op;
    end else begin
      req_a0 = a; req_b0 = b; req_op0 = op;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] pm;
    pm = v.port ? 2'b10 : 2'b01;
    drive_port(v.port, v.op, v.a, v.b);
    req_valid = pm;
    #1;
    chk("vec_req_ready", 64'(req_ready), 64'(pm));
    tick();
    req_valid = 2'b00;
    #1;
    chk("vec_exec_alu_op", 64'(alu_op), 64'(v.op));
    chk("vec_exec_no_resp", 64'(resp_valid), 64'd0);
    tick();
    chk("vec_resp_valid", 64'(resp_valid), 64'(pm));
    chk("vec_resp_result", 64'(resp_result), 64'(v.exp_result));
    chk("vec_resp_illegal", 64'(resp_illegal), 64'(v.exp_illegal));
    resp_ready = 2'b11;
    tick();
    resp_ready = 2'b00;
    chk("vec_back_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'b0010, 32'd5,          32'd7,  32'd12,         1'b0};
    vecs[1] = '{1'b1, 4'b0110, 32'd10,         32'd3,  32'd7,          1'b0};
    vecs[2] = '{1'b1, 4'b1101, 32'd1,          32'd4,  32'd16,         1'b0};
    vecs[3] = '{1'b0, 4'b0111, 32'hFFFF_FFFF,  32'd1,  32'd0,          1'b0};
    vecs[4] = '{1'b1, 4'b0000, 32'hF0F0_1234,  32'h0FF0_FFFF, 32'h00F0_1234, 1'b0};
    vecs[5] = '{1'b0, 4'b0001, 32'h8000_0000,  32'h1,  32'h8000_0001,  1'b0};
    vecs[6] = '{1'b0, 4'b1111, 32'd9,          32'd9,  32'd0,          1'b1};
    vecs[7] = '{1'b0, 4'b1100, 32'd0,          32'd0,  32'hFFFF_FFFF,  1'b0};
    vecs[8] = '{1'b1, 4'b0011, 32'd2,          32'd3,  32'd0,          1'b1};
    vecs[9] = '{1'b1, 4'b0010, 32'hFFFF_FFFF,  32'd2,  32'd1,          1'b0};

    reset = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0; req_op0 = 0; req_op1 = 0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(resp_result), 64'd0);
    chk("rst_illegal", 64'(resp_illegal), 64'd0);

    // Continuous tie with resp_ready held high: grants alternate every 3 cycles.
    drive_port(1'b0, 4'b0110, 32'd10, 32'd3);
    drive_port(1'b1, 4'b1101, 32'd1, 32'd4);
    req_valid = 2'b11; resp_ready = 2'b11;
    for (int cyc = 0; cyc < 12; cyc++) begin
      logic [1:0] exp_port;
      exp_port = ((cyc / 3) % 2 == 1) ? 2'b10 : 2'b01;
      #1;
      chk("alt_req_ready", 64'(req_ready), (cyc % 3 == 0) ? 64'(exp_port) : 64'd0);
      chk("alt_resp_valid", 64'(resp_valid), (cyc % 3 == 2) ? 64'(exp_port) : 64'd0);
      if (cyc % 3 == 2)
        chk("alt_result", 64'(resp_result), (exp_port == 2'b01) ? 64'd7 : 64'd16);
      tick();
    end
    req_valid = 2'b00; resp_ready = 2'b00;
    #1;

    // Port 1 SLT under backpressure; port 0 keeps asking, port 0 ready is ignored.
    drive_port(1'b1, 4'b0111, 32'd3, 32'd9);
    drive_port(1'b0, 4'b0010, 32'd1, 32'd1);
    req_valid = 2'b10;
    #1;
    chk("bp_req_ready", 64'(req_ready), 64'b10);
    tick();
    req_valid = 2'b01;
    #1;
    chk("bp_exec_req_ready", 64'(req_ready), 64'd0);
    tick();
    resp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_resp_valid", 64'(resp_valid), 64'b10);
      chk("bp_resp_result", 64'(resp_result), 64'd1);
      chk("bp_busy", 64'(busy), 64'd1);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      tick();
    end
    resp_ready = 2'b10;
    #1;
    chk("bp_complete_no_accept", 64'(req_ready), 64'd0);
    tick();
    resp_ready = 2'b00;
    #1;
    chk("bp_next_grant", 64'(req_ready), 64'b01);
    req_valid = 2'b00;
    tick();
    chk("drop_no_state_change", 64'(busy), 64'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset during EXEC of a port 1 request.
    drive_port(1'b1, 4'b0010, 32'd4, 32'd4);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    chk("mid_in_exec", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_alu_a", 64'(alu_a), 64'd0);
    chk("mid_alu_op", 64'(alu_op), 64'd0);
    tick();
    chk("mid_still_no_resp", 64'(resp_valid), 64'd0);
    req_valid = 2'b11;
    #1;
    chk("mid_tie_port0", 64'(req_ready), 64'b01);
    req_valid = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shares the single 32-bit combinational ALU between two requesters (port 0 and port 1, e.g. the execute stage and a multi-cycle helper unit) using round-robin arbitration. It drives the ALU's `a`, `b` and `op` inputs from registered operands and captures the ALU result into a response register. Each requester receives a valid/ready response. One operation is in flight at a time.

## Interface
- `WIDTH`, 32: operand and result width; must match the ALU.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid[1:0]`  in  2: per-port request valid.
- `req_ready[1:0]`  out  2: per-port request accepted this cycle.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  WIDTH each: per-port operands.
- `req_op0`, `req_op1`  in  4 each: per-port ALU op code.
- `resp_valid[1:0]`  out  2: per-port response valid.
- `resp_ready[1:0]`  in  2: per-port response consumed.
- `resp_result`  out  WIDTH: captured ALU result, shared by both ports.
- `resp_illegal`  out  1: the op code was not in the legal set. Qualified by `resp_valid`.
- `alu_a`, `alu_b`  out  WIDTH: to ALU `a`, `b`.
- `alu_op`  out  4: to ALU `op`.
- `alu_result`  in  WIDTH: from ALU `result`.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- **IDLE**
  - Grant: if exactly one `req_valid` bit is set, that port wins. If both are set, the port other than `last_grant` wins.
  - `req_ready[g]` = 1 combinationally for the winner `g` only. `req_ready` = 0 in all other states.
  - On handshake (`req_valid[g] & req_ready[g]`): latch the operands and op into `op_a`, `op_b`, `op_code`; set `owner` = `g` and `last_grant` = `g`; go to EXEC.
- **EXEC**
  - `alu_a`/`alu_b`/`alu_op` are driven from the latched registers.
  - At the clock edge ending EXEC: `resp_result` <= `alu_result`; `resp_illegal` <= (`op_code` not in {0000, 0001, 0010, 0110, 0111, 1100, 1101}); go to RESP.
- **RESP**
  - `resp_valid[owner]` = 1; the other bit = 0.
  - When `resp_ready[owner]` = 1: go to IDLE. `resp_ready` on the non-owner port is ignored.
- Illegal ops still complete normally. The ALU returns 0, so `resp_result` = 0 and `resp_illegal` = 1.
- Outside EXEC, `alu_a`/`alu_b`/`alu_op` hold the latched values. They are not zeroed.
- SLT is unsigned, as the ALU computes it. The arbiter does no arithmetic; results pass through at full `WIDTH`.

## Timing
- Reset (synchronous, takes effect on the edge where `reset`=1):
  - state = IDLE, `last_grant` = 1, so port 0 wins the first tie.
  - `op_a` = `op_b` = 0, `op_code` = 0000, `owner` = 0.
  - `resp_result` = 0, `resp_illegal` = 0.
  - Outputs: `resp_valid` = 00, `req_ready` = 00, `busy` = 0.
- Reset mid-operation (EXEC or RESP) abandons the operation. No response is produced, and `resp_valid` is 00 from the cycle after the reset edge.
- Latency: a handshake at cycle N gives EXEC at N+1 and `resp_valid` at N+2.
- Minimum spacing between accepts is 3 cycles, reached when `resp_ready` is held high.
- Backpressure: RESP holds `resp_result`, `resp_illegal` and `resp_valid` stable until consumed.
- Simultaneous events: a new request in the same cycle that RESP completes is not accepted. It is granted in the following IDLE cycle.
- `req_valid` may drop without a handshake. No request is latched and no state changes.

## Test plan
- Reset, then port 0 requests ADD a=5, b=7.
  - `req_ready` = 01 in the same cycle.
  - `alu_op` = 0010 one cycle later.
  - Two cycles later: `resp_valid` = 01, `resp_result` = 12, `resp_illegal` = 0.
- Both ports request continuously with `resp_ready` = 11: port 0 SUB 10-3, port 1 SLL 1<<4.
  - Grants alternate 0,1,0,1 (port 0 first after reset).
  - Results are 7 and 16.
  - Accepts occur every 3 cycles.
- Port 1 SLT a=3, b=9 with `resp_ready[1]` held low for 5 cycles.
  - `resp_valid` = 10 and `resp_result` = 1 stay stable throughout.
  - `busy` = 1 and `req_ready` = 00 throughout, even with `req_valid[0]` = 1.
- Port 0 op = 1111.
  - `resp_result` = 0, `resp_illegal` = 1.
  - The next legal op NOR a=0, b=0 returns 0xFFFFFFFF with `resp_illegal` = 0.
- `reset` asserted during EXEC of a port 1 request.
  - Next cycle: `resp_valid` = 00, `busy` = 0.
  - A subsequent tie is granted to port 0.
- `resp_ready[0]` = 1 while port 1 owns RESP: no completion. The state leaves RESP only on `resp_ready[1]`.
